// File: rtl/axis_pkt_gen.sv
// AXI Stream packet generator: emits num_pkts packets of pkt_len beats with a programmable idle gap.
// Define AXIS_PKT_GEN_LFSR_EN to replace the incrementing payload with a Galois LFSR.
module axis_pkt_gen #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    TUSER_WIDTH = 1,
  parameter int                    LEN_WIDTH   = 16,
  parameter int                    GAP_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY   = 8'hB8
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   start_i,
  input  logic [15:0]            num_pkts_i,
  input  logic [LEN_WIDTH-1:0]   pkt_len_i,
  input  logic [GAP_WIDTH-1:0]   gap_i,
  input  logic [DATA_WIDTH-1:0]  seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            pkt_count_o,
  input  logic                   m_axis_tready_i,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  output logic                   m_axis_tlast_o,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            num_pkts_q, num_pkts_d;
  logic [LEN_WIDTH-1:0]   last_idx_q, last_idx_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hs;

`ifdef AXIS_PKT_GEN_LFSR_EN
  // An all-zero LFSR state would lock up, so a zero seed starts from all-ones instead.
  function automatic logic [DATA_WIDTH-1:0] first_payload(input logic [DATA_WIDTH-1:0] seed);
    return (seed == '0) ? '1 : seed;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_payload(input logic [DATA_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] first_payload(input logic [DATA_WIDTH-1:0] seed);
    return seed;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_payload(input logic [DATA_WIDTH-1:0] v);
    return v + DATA_WIDTH'(1);
  endfunction

  logic unused_poly;
  assign unused_poly = ^LFSR_POLY;
`endif

  assign hs = tvalid_q & m_axis_tready_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    num_pkts_d = num_pkts_q;
    last_idx_d = last_idx_q;
    gap_d      = gap_q;
    beat_d     = beat_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          num_pkts_d = num_pkts_i;
          last_idx_d = (pkt_len_i == '0) ? '0 : pkt_len_i - LEN_WIDTH'(1);
          gap_d      = gap_i;
          beat_d     = '0;
          pkt_cnt_d  = '0;
          data_d     = first_payload(seed_i);
          state_d    = (num_pkts_i == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (hs) begin
          data_d = next_payload(data_q);
          if (beat_q == last_idx_q) begin
            beat_d    = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (pkt_cnt_d == num_pkts_q) begin
              state_d = DONE;
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) state_d = SEND;
        else                            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered with no extra latency.
    tvalid_d   = (state_d == SEND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    tlast_d    = tvalid_d && (beat_d == last_idx_d);
    tuser_d    = '0;
    tuser_d[0] = tvalid_d && (beat_d == '0);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      num_pkts_q <= '0;
      last_idx_q <= '0;
      gap_q      <= '0;
      beat_q     <= '0;
      gap_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
      data_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      num_pkts_q <= num_pkts_d;
      last_idx_q <= last_idx_d;
      gap_q      <= gap_d;
      beat_q     <= beat_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_q     <= data_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pkt_count_o     = pkt_cnt_q;
  assign m_axis_tdata_o  = data_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = tuser_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed table, backpressure/reset sequences, random runs
// compared beat-by-beat against a packet-list reference model.
`timescale 1ns/1ps
module tb_axis_pkt_gen;
  localparam int DW = 8;
  localparam int TW = 1;
  localparam int LW = 16;
  localparam int GW = 8;
  localparam logic [DW-1:0] POLY = 8'hB8;

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b1;
  logic          start_i = 1'b0;
  logic [15:0]   num_pkts_i = '0;
  logic [LW-1:0] pkt_len_i = '0;
  logic [GW-1:0] gap_i = '0;
  logic [DW-1:0] seed_i = '0;
  logic          busy_o, done_o;
  logic [15:0]   pkt_count_o;
  logic          m_axis_tready_i = 1'b0;
  logic [DW-1:0] m_axis_tdata_o;
  logic          m_axis_tvalid_o, m_axis_tlast_o;
  logic [TW-1:0] m_axis_tuser_o;

  always #5 clk_i = ~clk_i;

  axis_pkt_gen #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(TW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .LFSR_POLY(POLY)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_i(start_i), .num_pkts_i(num_pkts_i),
    .pkt_len_i(pkt_len_i), .gap_i(gap_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .pkt_count_o(pkt_count_o), .m_axis_tready_i(m_axis_tready_i), .m_axis_tdata_o(m_axis_tdata_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tuser_o(m_axis_tuser_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    logic [15:0]   pkts;
    logic [LW-1:0] len;
    logic [GW-1:0] gap;
    logic [DW-1:0] seed;
    int            exp_beats;
    int            exp_done;
    logic [DW-1:0] exp_last;
  } vec_t;

  beat_t         exp_q[$];
  logic [DW-1:0] cap [0:7];
  int            ncap;
  logic [DW-1:0] last_data;
  logic [5:0]    ready_pat = 6'b101001;  // consumed LSB first: 1,0,0,1,0,1

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole run as a flat list of beats.
  function automatic logic [DW-1:0] model_next(input logic [DW-1:0] v);
`ifdef AXIS_PKT_GEN_LFSR_EN
    return (v >> 1) ^ (v[0] ? POLY : 8'h00);
`else
    return v + 8'd1;
`endif
  endfunction

  task automatic build_expected(input logic [15:0] pkts, input logic [LW-1:0] len,
                                input logic [DW-1:0] seed);
    int            eff_len;
    logic [DW-1:0] v;
    beat_t         b;
    exp_q.delete();
    eff_len = (len == 0) ? 1 : int'(len);
    v = seed;
`ifdef AXIS_PKT_GEN_LFSR_EN
    if (seed == 0) v = 8'hFF;
`endif
    for (int p = 0; p < int'(pkts); p++) begin
      for (int i = 0; i < eff_len; i++) begin
        b.data = v;
        b.last = (i == eff_len - 1);
        b.user = (i == 0);
        exp_q.push_back(b);
        v = model_next(v);
      end
    end
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = fixed ready pattern.
  task automatic run_pkts(input logic [15:0] pkts, input logic [LW-1:0] len, input logic [GW-1:0] gap,
                          input logic [DW-1:0] seed, input int mode,
                          output int done_off, output int nbeats);
    int            gap_len;
    bit            in_gap, prev_stall;
    logic          v, rdy, pl, pu;
    logic [DW-1:0] pd;
    beat_t         e;
    build_expected(pkts, len, seed);
    ncap = 0; done_off = -1; nbeats = 0; in_gap = 0; prev_stall = 0; gap_len = 0;
    pd = '0; pl = 0; pu = 0; last_data = '0;
    @(negedge clk_i);
    num_pkts_i = pkts; pkt_len_i = len; gap_i = gap; seed_i = seed;
    start_i = 1'b1; m_axis_tready_i = 1'b1;
    for (int off = 1; off <= 2000; off++) begin
      @(negedge clk_i);
      v = m_axis_tvalid_o;
      start_i = 1'b0;
      if (off == 1) begin
        check("start_busy", busy_o, 1);
        check("start_valid", v, pkts != 0);
      end
      if (prev_stall) begin
        check("hold_valid", v, 1);
        check("hold_data", m_axis_tdata_o, pd);
        check("hold_last", m_axis_tlast_o, pl);
        check("hold_user", m_axis_tuser_o[0], pu);
      end
      if (in_gap) begin
        if (v) begin
          check("gap_len", gap_len, gap);
          in_gap = 0;
        end else begin
          gap_len++;
        end
      end
      if (done_o) begin
        done_off = off;
        break;
      end
      if (off == 1) begin
        // Start pulse and input changes while busy must be ignored.
        start_i = 1'b1; num_pkts_i = 16'd9; pkt_len_i = 7; gap_i = 5; seed_i = 8'hAA;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = ready_pat[(off - 1) % 6];
      endcase
      m_axis_tready_i = rdy;
      if (v && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata_o, e.data);
          check("beat_last", m_axis_tlast_o, e.last);
          check("beat_user", m_axis_tuser_o[0], e.user);
          if (e.last && exp_q.size() != 0) begin
            in_gap = 1; gap_len = 0;
          end
        end
        if (ncap < 8) cap[ncap++] = m_axis_tdata_o;
        last_data = m_axis_tdata_o;
        nbeats++;
      end
      prev_stall = v && !rdy;
      pd = m_axis_tdata_o; pl = m_axis_tlast_o; pu = m_axis_tuser_o[0];
    end
    if (done_off < 0) check("done_timeout", 0, 1);
    check("missing_beats", exp_q.size(), 0);
    check("pkt_count", pkt_count_o, pkts);
    @(negedge clk_i);
    start_i = 1'b0;
    check("done_pulse_len", done_o, 0);
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid_o, 0);
    check({tag, "_tdata"}, m_axis_tdata_o, 0);
    check({tag, "_tlast"}, m_axis_tlast_o, 0);
    check({tag, "_tuser"}, m_axis_tuser_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_count"}, pkt_count_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   d_off, nb;

    vecs[0] = '{pkts: 16'd2, len: 16'd4, gap: 8'd0, seed: 8'h10, exp_beats: 8, exp_done: 9, exp_last: 8'h17};
    vecs[1] = '{pkts: 16'd2, len: 16'd2, gap: 8'd3, seed: 8'h20, exp_beats: 4, exp_done: 8, exp_last: 8'h23};
    vecs[2] = '{pkts: 16'd3, len: 16'd0, gap: 8'd0, seed: 8'h30, exp_beats: 3, exp_done: 4, exp_last: 8'h32};
    vecs[3] = '{pkts: 16'd3, len: 16'd1, gap: 8'd1, seed: 8'h40, exp_beats: 3, exp_done: 6, exp_last: 8'h42};
    vecs[4] = '{pkts: 16'd0, len: 16'd5, gap: 8'd2, seed: 8'h50, exp_beats: 0, exp_done: 1, exp_last: 8'h00};
    vecs[5] = '{pkts: 16'd1, len: 16'd4, gap: 8'd0, seed: 8'hFE, exp_beats: 4, exp_done: 5, exp_last: 8'h01};

    #1 arstn_i = 1'b0;
    #2 check_outputs_zero("reset");
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_pkts(vecs[i].pkts, vecs[i].len, vecs[i].gap, vecs[i].seed, 0, d_off, nb);
      check("vec_beats", nb, vecs[i].exp_beats);
      check("vec_done_time", d_off, vecs[i].exp_done);
`ifndef AXIS_PKT_GEN_LFSR_EN
      if (vecs[i].exp_beats > 0) check("vec_last_data", last_data, vecs[i].exp_last);
`endif
    end

`ifndef AXIS_PKT_GEN_LFSR_EN
    run_pkts(16'd1, 16'd4, 8'd0, 8'hFE, 0, d_off, nb);
    check("wrap_0", cap[0], 8'hFE);
    check("wrap_1", cap[1], 8'hFF);
    check("wrap_2", cap[2], 8'h00);
    check("wrap_3", cap[3], 8'h01);
`else
    run_pkts(16'd1, 16'd4, 8'd0, 8'h01, 0, d_off, nb);
    check("lfsr_0", cap[0], 8'h01);
    check("lfsr_1", cap[1], 8'hB8);
    check("lfsr_2", cap[2], 8'h5C);
    check("lfsr_3", cap[3], 8'h2E);
    run_pkts(16'd1, 16'd1, 8'd0, 8'h00, 0, d_off, nb);
    check("lfsr_seed0", cap[0], 8'hFF);
`endif

    // Backpressure 1,0,0,1,0,1 on a 3-beat packet: handshakes at offsets 1, 4, 6.
    run_pkts(16'd1, 16'd3, 8'd0, 8'h60, 2, d_off, nb);
    check("bp_beats", nb, 3);
    check("bp_done_time", d_off, 7);
`ifndef AXIS_PKT_GEN_LFSR_EN
    check("bp_data0", cap[0], 8'h60);
    check("bp_data1", cap[1], 8'h61);
    check("bp_data2", cap[2], 8'h62);
`endif

    // Reset in the middle of a packet: outputs clear at once and the run is not resumed.
    @(negedge clk_i);
    num_pkts_i = 16'd2; pkt_len_i = 16'd8; gap_i = 8'd0; seed_i = 8'h33;
    start_i = 1'b1; m_axis_tready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("pre_reset_valid", m_axis_tvalid_o, 1);
    #2 arstn_i = 1'b0;
    #1 check_outputs_zero("midrun_reset");
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    check("no_resume_valid", m_axis_tvalid_o, 0);
    check("no_resume_busy", busy_o, 0);
    run_pkts(16'd2, 16'd3, 8'd1, 8'h40, 0, d_off, nb);
    check("post_reset_beats", nb, 6);
    check("post_reset_done", d_off, 8);

    for (int r = 0; r < 10; r++) begin
      logic [15:0]   rp;
      logic [LW-1:0] rl;
      logic [GW-1:0] rg;
      logic [DW-1:0] rs;
      int            el;
      rp = 16'($urandom_range(0, 4));
      rl = LW'($urandom_range(0, 6));
      rg = GW'($urandom_range(0, 4));
      rs = DW'($urandom);
      el = (rl == 0) ? 1 : int'(rl);
      run_pkts(rp, rl, rg, rs, 1, d_off, nb);
      check("rand_beats", nb, int'(rp) * el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI Stream packet generator: a master-only traffic source that emits a programmed number of packets of fixed length with a deterministic payload and a programmable idle gap between packets. It drives `axis_fifo` and other AXIS sinks in block-level benches and on-chip loopback/self-test paths. Its sink-side counterpart is a packet checker.

## Interface
Parameters:
- `DATA_WIDTH`, 8: tdata width.
- `TUSER_WIDTH`, 1: tuser width, minimum 1.
- `LEN_WIDTH`, 16: packet-length field width.
- `GAP_WIDTH`, 8: inter-packet gap field width.
- `LFSR_POLY`, 8'hB8: Galois tap mask, `DATA_WIDTH` bits. Used only with `AXIS_PKT_GEN_LFSR_EN`.

Ports:
- `clk_i` in 1: clock.
- `arstn_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start a run. Sampled only in IDLE.
- `num_pkts_i` in 16: packets per run.
- `pkt_len_i` in `LEN_WIDTH`: beats per packet. A value of 0 is treated as 1.
- `gap_i` in `GAP_WIDTH`: idle cycles between packets.
- `seed_i` in `DATA_WIDTH`: first payload value.
- `busy_o` out 1: a run is in progress.
- `done_o` out 1: one-cycle pulse when a run ends.
- `pkt_count_o` out 16: packets completed in the current or last run.
- `m_axis_tready_i` in 1: sink ready.
- `m_axis_tdata_o` out `DATA_WIDTH`: payload.
- `m_axis_tvalid_o` out 1: beat valid.
- `m_axis_tlast_o` out 1: last beat of packet.
- `m_axis_tuser_o` out `TUSER_WIDTH`: bit 0 is start-of-packet; upper bits are 0.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- **IDLE**: `start_i`=1 latches `num_pkts_i`, `pkt_len_i`, `gap_i` and `seed_i`, and clears `pkt_count_o` and the beat index.
  - If `num_pkts_i`=0, go to DONE.
  - Otherwise go to SEND.
- **SEND**: `tvalid`=1. A handshake occurs when tvalid & tready.
  - On a handshake of a non-last beat: advance the payload and the beat index.
  - On a handshake of the last beat (index = len−1, `tlast`=1): increment `pkt_count_o` and reset the beat index.
  - After the last beat, if it was the final packet, go to DONE.
  - Otherwise, if gap=0, stay in SEND; the next packet's first beat is presented the next cycle.
  - Otherwise go to GAP.
- **GAP**: `tvalid`=0 for exactly `gap` cycles (down-counter), then go to SEND.
- **DONE**: `done_o`=1 for one cycle, then go to IDLE.
- `busy_o`=1 in SEND, GAP and DONE.
- `start_i` is ignored outside IDLE. Input changes during a run have no effect.
- Payload (default): an incrementing counter, starting at `seed_i` and adding 1 per accepted beat.
  - It continues across packet boundaries within a run.
  - It wraps modulo 2^`DATA_WIDTH`.
- `tuser[0]`=1 only on beat index 0 of each packet. With len=1, `tuser[0]` and `tlast` are both 1.
- AXIS rule: while `tvalid`=1 and `tready`=0, tdata, tlast and tuser hold stable and tvalid stays high.
- `pkt_count_o` wraps at 2^16. `num_pkts_i`=65535 is the maximum run.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- Start latency: `start_i` high at cycle N gives `tvalid`=1 and `busy_o`=1 at N+1.
- Throughput is one beat per cycle while `tready`=1, including back-to-back packets when gap=0.
- Gap timing: last-beat handshake at cycle M gives `tvalid`=0 for cycles M+1 … M+gap, and the first beat of the next packet at M+gap+1.
- Done timing: final-beat handshake at cycle M gives `done_o`=1 at M+1, then `busy_o`=0 at M+2.
  - A new `start_i` is accepted at M+2.
  - For `num_pkts_i`=0, `done_o` is at N+1.
- Reset mid-run: outputs drop to 0 asynchronously. No partial packet is resumed after reset.

## Configuration
- Macro: `AXIS_PKT_GEN_LFSR_EN`.
- **Defined**: the payload is a Galois LFSR.
  - Update per accepted beat: next = (v >> 1) ^ (v[0] ? `LFSR_POLY` : 0).
  - The first beat equals the seed.
  - A seed of 0 is replaced by all-ones.
- **Undefined**: incrementing counter payload. `LFSR_POLY` is unused.

## Test plan
- **Basic run**: seed=8'h10, len=4, pkts=2, gap=0, tready=1.
  - Expect data 10,11,12,13,14,15,16,17 on consecutive cycles.
  - Expect `tlast` on 13 and 17, and `tuser` on 10 and 14.
  - Expect `done_o` one cycle after 17, and `pkt_count_o`=2.
- **Gap**: len=2, pkts=2, gap=3.
  - Expect exactly 3 cycles with `tvalid`=0 between the `tlast` handshake and the next first beat.
- **Backpressure**: len=3, with tready toggling 1,0,0,1,0,1.
  - Expect tdata, tlast and tuser held while stalled.
  - Expect no beat dropped or duplicated, and data seed..seed+2.
- **Edge lengths**: len=0 and len=1, pkts=3.
  - Expect every beat to have `tlast`=1 and `tuser`=1.
  - Separately, pkts=0: expect `done_o` at N+1 with no beats.
- **Wrap and robustness**: seed=8'hFE, len=4.
  - Expect data FE,FF,00,01.
  - Assert `start_i` while busy: no effect.
  - Drop `arstn_i` mid-packet: all outputs 0 immediately; a fresh run afterwards is correct.
- **LFSR** (with `AXIS_PKT_GEN_LFSR_EN`): seed=8'h01, poly=8'hB8.
  - Expect data 01,B8,5C,2E.
  - Seed=0: expect first beat FF.
